// File: rtl/sync_fifo_thresh_buffer.sv
// Single-clock circular FIFO with occupancy count, programmable almost-full/empty
// flags, flush, sticky overflow/underflow, and selectable FWFT or registered read.
module sync_fifo_thresh_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 32,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            write_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            read_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  output logic                            rd_valid_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            overflow_o,
  output logic                            underflow_o
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam bit POW2 = (FIFO_DEPTH == (1 << PW));

  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_nxt;
  logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic                  wr_en, rd_en, wr_go, rd_go;

  // Acceptance uses the registered flags only, so no request-to-flag comb path exists.
  assign wr_en = write_i & ~full_q;
  assign rd_en = read_i  & ~empty_q;
  assign wr_go = wr_en & ~rst_i & ~flush_i;
  assign rd_go = rd_en & ~rst_i & ~flush_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (POW2) return p + 1'b1;
    else      return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count_q  <= count_nxt;
      full_q   <= (count_nxt == DEPTH_C);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= AF_C);
      aempty_q <= (count_nxt <= AE_C);
      if (write_i && full_q) ovf_q <= 1'b1;
      if (read_i && empty_q) unf_q <= 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_go) mem[wr_ptr] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o  = empty_q ? '0 : mem[rd_ptr];
      assign rd_valid_o = ~empty_q;
    end else begin : g_regrd
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;
      // Flush drops the valid pulse but keeps the last word on the bus.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush_i) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_go;
          if (rd_go) rd_data_q <= mem[rd_ptr];
        end
      end
      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
endmodule

// File: tb/tb_sync_fifo_thresh_buffer.sv
// Directed bench: a FWFT and a registered-read FIFO (depth 5, AF=4, AE=1) share stimulus.
module tb_sync_fifo_thresh_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wdat = '0;

  logic [7:0] f_data, r_data;
  logic [2:0] f_count, r_count;
  logic f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic r_valid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_thresh_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1),
                            .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(wr), .wr_data_i(wdat), .read_i(rd),
    .rd_data_o(f_data), .rd_valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf));

  sync_fifo_thresh_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0),
                            .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(wr), .wr_data_i(wdat), .read_i(rd),
    .rd_data_o(r_data), .rd_valid_o(r_valid), .full_o(r_full), .empty_o(r_empty),
    .almost_full_o(r_afull), .almost_empty_o(r_aempty), .count_o(r_count),
    .overflow_o(r_ovf), .underflow_o(r_unf));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", f_count); end
    n_chk++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", f_empty); end
    n_chk++; if (f_aempty !== 1'b1) begin n_err++; $display("FAIL rst_aempty: got %b want 1", f_aempty); end
    n_chk++; if (f_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", f_full); end
    n_chk++; if (f_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull: got %b want 0", f_afull); end
    n_chk++; if ({f_ovf, f_unf} !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b%b want 00", f_ovf, f_unf); end
    n_chk++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL rst_fvalid: got %b want 0", f_valid); end
    n_chk++; if (f_data !== 8'h00) begin n_err++; $display("FAIL rst_fdata: got %h want 00", f_data); end
    n_chk++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", r_valid); end
    n_chk++; if (r_data !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", r_data); end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdat = 8'(8'hA0 + i); tick();
    end
    wr = 1'b0;
    n_chk++; if (f_count !== 3'd5) begin n_err++; $display("FAIL basic_count5: got %0d want 5", f_count); end
    n_chk++; if (f_full !== 1'b1) begin n_err++; $display("FAIL basic_full: got %b want 1", f_full); end
    for (int i = 0; i < 5; i++) begin
      exp = 8'(8'hA0 + i);
      n_chk++; if (f_data !== exp) begin n_err++; $display("FAIL basic_fdata%0d: got %h want %h", i, f_data, exp); end
      n_chk++; if (f_count !== 3'(5 - i)) begin n_err++; $display("FAIL basic_cnt%0d: got %0d want %0d", i, f_count, 5 - i); end
      rd = 1'b1; tick(); rd = 1'b0;
      n_chk++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL basic_rvalid%0d: got %b want 1", i, r_valid); end
      n_chk++; if (r_data !== exp) begin n_err++; $display("FAIL basic_rdata%0d: got %h want %h", i, r_data, exp); end
    end
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL basic_count0: got %0d want 0", f_count); end
    n_chk++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b want 1", f_empty); end
    n_chk++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL basic_fvalid: got %b want 0", f_valid); end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 5; k++) begin
      wr = 1'b1; wdat = 8'(8'h30 + k); #1;
      n_chk++; if (f_aempty !== ((k - 1) <= 1)) begin n_err++; $display("FAIL thr_pre_ae%0d: got %b want %b", k, f_aempty, ((k - 1) <= 1)); end
      n_chk++; if (f_afull !== ((k - 1) >= 4)) begin n_err++; $display("FAIL thr_pre_af%0d: got %b want %b", k, f_afull, ((k - 1) >= 4)); end
      tick();
      n_chk++; if (f_count !== 3'(k)) begin n_err++; $display("FAIL thr_cnt%0d: got %0d want %0d", k, f_count, k); end
      n_chk++; if (f_aempty !== (k <= 1)) begin n_err++; $display("FAIL thr_ae%0d: got %b want %b", k, f_aempty, (k <= 1)); end
      n_chk++; if (f_afull !== (k >= 4)) begin n_err++; $display("FAIL thr_af%0d: got %b want %b", k, f_afull, (k >= 4)); end
    end
    wr = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      rd = 1'b1; tick();
      n_chk++; if (f_aempty !== (k <= 1)) begin n_err++; $display("FAIL thr_dr_ae%0d: got %b want %b", k, f_aempty, (k <= 1)); end
      n_chk++; if (f_afull !== (k >= 4)) begin n_err++; $display("FAIL thr_dr_af%0d: got %b want %b", k, f_afull, (k >= 4)); end
    end
    rd = 1'b0;
  endtask

  task automatic test_simultaneous();
    wr = 1'b1; rd = 1'b1; wdat = 8'h40; tick(); rd = 1'b0;
    n_chk++; if (f_count !== 3'd1) begin n_err++; $display("FAIL sim0_count: got %0d want 1", f_count); end
    n_chk++; if (f_unf !== 1'b1) begin n_err++; $display("FAIL sim0_unf: got %b want 1", f_unf); end
    n_chk++; if (f_data !== 8'h40) begin n_err++; $display("FAIL sim0_data: got %h want 40", f_data); end
    wdat = 8'h41; tick(); wdat = 8'h42; tick();
    rd = 1'b1; wdat = 8'h43; tick(); rd = 1'b0;
    n_chk++; if (f_count !== 3'd3) begin n_err++; $display("FAIL sim3_count: got %0d want 3", f_count); end
    n_chk++; if (f_data !== 8'h41) begin n_err++; $display("FAIL sim3_data: got %h want 41", f_data); end
    wdat = 8'h44; tick(); wdat = 8'h45; tick();
    n_chk++; if (f_full !== 1'b1) begin n_err++; $display("FAIL sim_full: got %b want 1", f_full); end
    rd = 1'b1; wdat = 8'h46; tick(); wr = 1'b0; rd = 1'b0;
    n_chk++; if (f_count !== 3'd4) begin n_err++; $display("FAIL simF_count: got %0d want 4", f_count); end
    n_chk++; if (f_ovf !== 1'b1) begin n_err++; $display("FAIL simF_ovf: got %b want 1", f_ovf); end
    n_chk++; if (f_data !== 8'h42) begin n_err++; $display("FAIL simF_data: got %h want 42", f_data); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_chk++; if (f_count !== 3'd3) begin n_err++; $display("FAIL simR_count: got %0d want 3", f_count); end
    n_chk++; if (f_data !== 8'h43) begin n_err++; $display("FAIL simR_data: got %h want 43", f_data); end
    n_chk++; if (r_data !== 8'h42) begin n_err++; $display("FAIL simR_rdata: got %h want 42", r_data); end
  endtask

  task automatic test_flush();
    flush = 1'b1; wr = 1'b1; wdat = 8'h77; tick(); flush = 1'b0; wr = 1'b0;
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL fl_count: got %0d want 0", f_count); end
    n_chk++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL fl_empty: got %b want 1", f_empty); end
    n_chk++; if ({f_ovf, f_unf} !== 2'b00) begin n_err++; $display("FAIL fl_err: got %b%b want 00", f_ovf, f_unf); end
    n_chk++; if (f_data !== 8'h00) begin n_err++; $display("FAIL fl_fdata: got %h want 00", f_data); end
    n_chk++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL fl_rvalid: got %b want 0", r_valid); end
    n_chk++; if (r_data !== 8'h42) begin n_err++; $display("FAIL fl_rdata_hold: got %h want 42", r_data); end
    tick();
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL fl_count_after: got %0d want 0", f_count); end
  endtask

  task automatic test_overflow_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdat = 8'(8'h10 + i); tick();
    end
    n_chk++; if (f_count !== 3'd5) begin n_err++; $display("FAIL ov_count5: got %0d want 5", f_count); end
    n_chk++; if (f_ovf !== 1'b0) begin n_err++; $display("FAIL ov_pre: got %b want 0", f_ovf); end
    wdat = 8'h15; tick(); wr = 1'b0;
    n_chk++; if (f_ovf !== 1'b1) begin n_err++; $display("FAIL ov_set: got %b want 1", f_ovf); end
    n_chk++; if (f_count !== 3'd5) begin n_err++; $display("FAIL ov_count: got %0d want 5", f_count); end
    tick();
    n_chk++; if (f_ovf !== 1'b1) begin n_err++; $display("FAIL ov_sticky: got %b want 1", f_ovf); end
    n_chk++; if (f_data !== 8'h10) begin n_err++; $display("FAIL ov_head: got %h want 10", f_data); end
    rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp = (i < 4) ? 8'(8'h11 + i) : 8'(8'h20 + i - 4);
      n_chk++; if (f_data !== exp) begin n_err++; $display("FAIL wrap_data%0d: got %h want %h", i, f_data, exp); end
      wr = 1'b1; rd = 1'b1; wdat = 8'(8'h20 + i); tick();
      n_chk++; if (f_count !== 3'd4) begin n_err++; $display("FAIL wrap_cnt%0d: got %0d want 4", i, f_count); end
    end
    wr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp = 8'(8'h28 + j);
      n_chk++; if (f_data !== exp) begin n_err++; $display("FAIL drain_data%0d: got %h want %h", j, f_data, exp); end
      tick();
    end
    rd = 1'b0;
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", f_count); end
    n_chk++; if ({f_ovf, f_unf} !== 2'b10) begin n_err++; $display("FAIL drain_err: got %b%b want 10", f_ovf, f_unf); end
  endtask

  task automatic test_registered_read();
    wr = 1'b1; wdat = 8'h50; tick(); wdat = 8'h51; tick(); wr = 1'b0;
    n_chk++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle_valid: got %b want 0", r_valid); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_chk++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid: got %b want 1", r_valid); end
    n_chk++; if (r_data !== 8'h50) begin n_err++; $display("FAIL rr_data: got %h want 50", r_data); end
    n_chk++; if (r_count !== 3'd1) begin n_err++; $display("FAIL rr_count: got %0d want 1", r_count); end
    tick();
    n_chk++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL rr_pulse_end: got %b want 0", r_valid); end
    n_chk++; if (r_data !== 8'h50) begin n_err++; $display("FAIL rr_hold: got %h want 50", r_data); end
  endtask

  task automatic test_reset_mid_burst();
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin wdat = 8'(8'h60 + i); tick(); end
    rst = 1'b1; rd = 1'b1; wdat = 8'h63; tick(); rst = 1'b0; wr = 1'b0; rd = 1'b0;
    n_chk++; if (f_count !== 3'd0) begin n_err++; $display("FAIL mr_count: got %0d want 0", f_count); end
    n_chk++; if ({f_empty, f_aempty} !== 2'b11) begin n_err++; $display("FAIL mr_empty: got %b%b want 11", f_empty, f_aempty); end
    n_chk++; if ({f_full, f_afull} !== 2'b00) begin n_err++; $display("FAIL mr_full: got %b%b want 00", f_full, f_afull); end
    n_chk++; if ({f_ovf, f_unf} !== 2'b00) begin n_err++; $display("FAIL mr_err: got %b%b want 00", f_ovf, f_unf); end
    n_chk++; if ({f_valid, f_data} !== 9'h000) begin n_err++; $display("FAIL mr_fout: got %b/%h want 0/00", f_valid, f_data); end
    n_chk++; if ({r_valid, r_data} !== 9'h000) begin n_err++; $display("FAIL mr_rout: got %b/%h want 0/00", r_valid, r_data); end
    n_chk++; if (r_count !== 3'd0) begin n_err++; $display("FAIL mr_rcount: got %0d want 0", r_count); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_thresholds();
    test_simultaneous();
    test_flush();
    test_overflow_wrap();
    test_registered_read();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
